// File: rtl/fetch_unit.sv
// Instruction fetch stage: pulls a one- or two-byte instruction from program memory at the PC,
// strobes the PC forward/loads, and hands the result to the decoder via a valid/accept handshake.
module fetch_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_value,
    output logic                  pc_step,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  instr_valid,
    input  logic                  instr_accept,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  has_operand,
    input  logic                  jump_req,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  fetch_error
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    // Last waiting cycle: counter already holds MEM_TIMEOUT-1, so this cycle makes it MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        START     = 3'd0,
        FETCH_OP  = 3'd1,
        FETCH_ARG = 3'd2,
        HOLD      = 3'd3,
        ERROR     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] operand_q, operand_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= START;
            cnt_q     <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        opcode_d      = opcode_q;
        operand_d     = operand_q;
        pc_step       = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        mem_read      = 1'b0;
        mem_addr      = '0;

        case (state_q)
            START: begin
                state_d = FETCH_OP;
            end

            FETCH_OP: begin
                mem_read = 1'b1;
                mem_addr = pc_value;
                if (jump_req) begin
                    pc_load       = 1'b1;
                    pc_load_value = jump_addr;
                    state_d       = FETCH_OP;
                end else if (mem_ready) begin
                    opcode_d = mem_data;
                    pc_step  = 1'b1;
                    if (mem_data[DATA_WIDTH-1]) begin
                        state_d = FETCH_ARG;
                    end else begin
                        operand_d = '0;
                        state_d   = HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FETCH_ARG: begin
                mem_read = 1'b1;
                mem_addr = pc_value;
                if (jump_req) begin
                    pc_load       = 1'b1;
                    pc_load_value = jump_addr;
                    state_d       = FETCH_OP;
                end else if (mem_ready) begin
                    operand_d = mem_data;
                    pc_step   = 1'b1;
                    state_d   = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HOLD: begin
                // A jump arriving with accept still lets the decoder take this instruction.
                if (jump_req) begin
                    pc_load       = 1'b1;
                    pc_load_value = jump_addr;
                    state_d       = FETCH_OP;
                end else if (instr_accept) begin
                    state_d = FETCH_OP;
                end
            end

            ERROR: begin
                if (jump_req) begin
                    pc_load       = 1'b1;
                    pc_load_value = jump_addr;
                    state_d       = FETCH_OP;
                end
            end

            default: begin
                state_d = START;
            end
        endcase
    end

    assign instr_valid = (state_q == HOLD);
    assign fetch_error = (state_q == ERROR);
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign has_operand = opcode_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural PC and program memory surround the DUT, and each
// task walks one scenario cycle by cycle, checking outputs just after the falling edge.
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] pc_value;
    logic       pc_step, pc_load;
    logic [7:0] pc_load_value;
    logic       mem_read;
    logic [7:0] mem_addr;
    logic       mem_ready;
    logic [7:0] mem_data;
    logic       instr_valid, instr_accept;
    logic [7:0] opcode, operand;
    logic       has_operand;
    logic       jump_req;
    logic [7:0] jump_addr;
    logic       fetch_error;

    logic [7:0] mem [0:255];
    logic       pc_set;
    logic [7:0] pc_set_val;
    int         errors = 0;
    int         checks = 0;

    fetch_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .pc_value(pc_value),
        .pc_step(pc_step), .pc_load(pc_load), .pc_load_value(pc_load_value),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_accept(instr_accept),
        .opcode(opcode), .operand(operand), .has_operand(has_operand),
        .jump_req(jump_req), .jump_addr(jump_addr), .fetch_error(fetch_error)
    );

    always #5 clock = ~clock;

    assign mem_data = mem[mem_addr];

    // Program counter the fetch unit drives through its step/load strobes.
    always @(posedge clock) begin
        if (pc_set)       pc_value <= pc_set_val;
        else if (pc_load) pc_value <= pc_load_value;
        else if (pc_step) pc_value <= pc_value + 8'd1;
    end

    task automatic test_reset;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if ({pc_step, pc_load, fetch_error} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {pc_step, pc_load, fetch_error}); end
        checks++; if ({opcode, operand} !== 16'h0000) begin errors++; $display("FAIL rst_regs: got %h want 0000", {opcode, operand}); end
        @(negedge clock);
        reset = 1'b0; pc_set = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL start_no_req: got %b want 0", mem_read); end
        $display("test_reset done");
    endtask

    task automatic test_one_byte;
        @(negedge clock);
        mem_ready = 1'b1;
        #1;
        checks++; if ({mem_read, mem_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL t1_req: got %b/%h want 1/00", mem_read, mem_addr); end
        checks++; if (pc_step !== 1'b1) begin errors++; $display("FAIL t1_step: got %b want 1", pc_step); end
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b want 1", instr_valid); end
        checks++; if ({opcode, operand, has_operand} !== {8'h12, 8'h00, 1'b0}) begin errors++; $display("FAIL t1_instr: got %h %h %b want 12 00 0", opcode, operand, has_operand); end
        checks++; if ({pc_step, mem_read} !== 2'b00) begin errors++; $display("FAIL t1_hold_quiet: got %b want 00", {pc_step, mem_read}); end
        checks++; if (pc_value !== 8'h01) begin errors++; $display("FAIL t1_pc: got %h want 01", pc_value); end
        @(negedge clock);
        #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL t1_held: got %b want 1", instr_valid); end
        @(negedge clock);
        instr_accept = 1'b1;
        $display("test_one_byte done");
    endtask

    task automatic test_two_byte;
        @(negedge clock);
        instr_accept = 1'b0; pc_set = 1'b1; pc_set_val = 8'h05;
        #1;
        checks++; if ({instr_valid, mem_read} !== 2'b01) begin errors++; $display("FAIL t2_after_accept: got %b want 01", {instr_valid, mem_read}); end
        @(negedge clock);
        pc_set = 1'b0; mem_ready = 1'b1;
        #1;
        checks++; if ({mem_addr, pc_step} !== {8'h05, 1'b1}) begin errors++; $display("FAIL t2_op: got %h/%b want 05/1", mem_addr, pc_step); end
        @(negedge clock);
        #1;
        checks++; if ({mem_read, mem_addr, pc_step, instr_valid} !== {1'b1, 8'h06, 1'b1, 1'b0}) begin errors++; $display("FAIL t2_arg: got %b/%h/%b/%b want 1/06/1/0", mem_read, mem_addr, pc_step, instr_valid); end
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        checks++; if ({instr_valid, opcode, operand, has_operand} !== {1'b1, 8'h83, 8'h4A, 1'b1}) begin errors++; $display("FAIL t2_instr: got %b %h %h %b want 1 83 4a 1", instr_valid, opcode, operand, has_operand); end
        checks++; if (pc_value !== 8'h07) begin errors++; $display("FAIL t2_pc: got %h want 07", pc_value); end
        instr_accept = 1'b1;
        $display("test_two_byte done");
    endtask

    task automatic test_wrap;
        mem[8'hFF] = 8'h90; mem[8'h00] = 8'h77;
        @(negedge clock);
        instr_accept = 1'b0; pc_set = 1'b1; pc_set_val = 8'hFF;
        @(negedge clock);
        pc_set = 1'b0; mem_ready = 1'b1;
        #1;
        checks++; if ({mem_addr, pc_step} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL t3_op: got %h/%b want ff/1", mem_addr, pc_step); end
        @(negedge clock);
        #1;
        checks++; if ({mem_addr, pc_step} !== {8'h00, 1'b1}) begin errors++; $display("FAIL t3_arg: got %h/%b want 00/1", mem_addr, pc_step); end
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        checks++; if ({instr_valid, opcode, operand, fetch_error} !== {1'b1, 8'h90, 8'h77, 1'b0}) begin errors++; $display("FAIL t3_instr: got %b %h %h %b want 1 90 77 0", instr_valid, opcode, operand, fetch_error); end
        instr_accept = 1'b1;
        $display("test_wrap done");
    endtask

    task automatic test_timeout_edge;
        mem[8'h01] = 8'h01;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            instr_accept = 1'b0; mem_ready = 1'b0;
        end
        @(negedge clock);
        mem_ready = 1'b1;
        #1;
        checks++; if ({pc_step, mem_addr} !== {1'b1, 8'h01}) begin errors++; $display("FAIL tedge_step: got %b/%h want 1/01", pc_step, mem_addr); end
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        checks++; if ({fetch_error, instr_valid, opcode} !== {1'b0, 1'b1, 8'h01}) begin errors++; $display("FAIL tedge_ready_wins: got %b %b %h want 0 1 01", fetch_error, instr_valid, opcode); end
        instr_accept = 1'b1;
        $display("test_timeout_edge done");
    endtask

    task automatic test_timeout;
        int reqs = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            instr_accept = 1'b0; mem_ready = 1'b0;
            #1;
            if (mem_read === 1'b1) reqs++;
            if (i == 14) begin
                checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL t4_early_err: got %b want 0", fetch_error); end
            end
        end
        checks++; if (reqs !== 15) begin errors++; $display("FAIL t4_req_cycles: got %0d want 15", reqs); end
        @(negedge clock);
        #1;
        checks++; if ({fetch_error, mem_read, instr_valid} !== 3'b100) begin errors++; $display("FAIL t4_error: got %b want 100", {fetch_error, mem_read, instr_valid}); end
        @(negedge clock);
        mem_ready = 1'b1;
        #1;
        checks++; if ({fetch_error, pc_step} !== 2'b10) begin errors++; $display("FAIL t4_sticky: got %b want 10", {fetch_error, pc_step}); end
        @(negedge clock);
        mem_ready = 1'b0; jump_req = 1'b1; jump_addr = 8'h40;
        #1;
        checks++; if ({pc_load, pc_load_value, pc_step} !== {1'b1, 8'h40, 1'b0}) begin errors++; $display("FAIL t4_jump: got %b/%h/%b want 1/40/0", pc_load, pc_load_value, pc_step); end
        @(negedge clock);
        jump_req = 1'b0;
        #1;
        checks++; if ({fetch_error, mem_read, mem_addr, pc_load} !== {1'b0, 1'b1, 8'h40, 1'b0}) begin errors++; $display("FAIL t4_resume: got %b %b %h %b want 0 1 40 0", fetch_error, mem_read, mem_addr, pc_load); end
        $display("test_timeout done");
    endtask

    task automatic test_jump_arg;
        mem[8'h40] = 8'h85; mem[8'h41] = 8'h33;
        @(negedge clock);
        mem_ready = 1'b1;
        #1;
        checks++; if (pc_step !== 1'b1) begin errors++; $display("FAIL t5_op_step: got %b want 1", pc_step); end
        @(negedge clock);
        jump_req = 1'b1; jump_addr = 8'h20;
        #1;
        checks++; if ({pc_step, pc_load, pc_load_value} !== {1'b0, 1'b1, 8'h20}) begin errors++; $display("FAIL t5_jump_wins: got %b/%b/%h want 0/1/20", pc_step, pc_load, pc_load_value); end
        @(negedge clock);
        jump_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++; if ({instr_valid, mem_read, mem_addr} !== {1'b0, 1'b1, 8'h20}) begin errors++; $display("FAIL t5_redirect: got %b %b %h want 0 1 20", instr_valid, mem_read, mem_addr); end
        @(negedge clock);
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t5_no_valid: got %b want 0", instr_valid); end
        $display("test_jump_arg done");
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_op;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            instr_accept = 1'b1; mem_ready = 1'b1;
            #1;
            checks++; if (instr_valid !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, instr_valid, (i % 2 == 1)); end
            if (i % 2 == 1) begin
                exp_op = (i == 1) ? 8'h01 : 8'h02;
                checks++; if (opcode !== exp_op) begin errors++; $display("FAIL b2b_op[%0d]: got %h want %h", i, opcode, exp_op); end
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        instr_accept = 1'b0; mem_ready = 1'b0; pc_set = 1'b1; pc_set_val = 8'h05;
        @(negedge clock);
        pc_set = 1'b0; mem_ready = 1'b1;
        #1;
        checks++; if ({pc_step, mem_addr} !== {1'b1, 8'h05}) begin errors++; $display("FAIL t6_op: got %b/%h want 1/05", pc_step, mem_addr); end
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        checks++; if ({mem_read, mem_addr} !== {1'b1, 8'h06}) begin errors++; $display("FAIL t6_in_arg: got %b/%h want 1/06", mem_read, mem_addr); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if ({mem_read, mem_addr, pc_step, instr_valid} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin errors++; $display("FAIL t6_async_out: got %b %h %b %b want 0 00 0 0", mem_read, mem_addr, pc_step, instr_valid); end
        checks++; if ({opcode, operand} !== 16'h0000) begin errors++; $display("FAIL t6_async_regs: got %h want 0000", {opcode, operand}); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t6_start: got %b want 0", mem_read); end
        @(negedge clock);
        #1;
        checks++; if ({mem_read, mem_addr} !== {1'b1, 8'h06}) begin errors++; $display("FAIL t6_restart: got %b/%h want 1/06", mem_read, mem_addr); end
        $display("test_reset_mid done");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h12; mem[8'h05] = 8'h83; mem[8'h06] = 8'h4A;
        reset = 1'b1; mem_ready = 1'b0; instr_accept = 1'b0;
        jump_req = 1'b0; jump_addr = 8'h00; pc_set = 1'b1; pc_set_val = 8'h00;
        test_reset;
        test_one_byte;
        test_two_byte;
        test_wrap;
        test_timeout_edge;
        test_timeout;
        test_jump_arg;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
